dmem_responder: RTL and testbench
=================================

# dmem_responder

Memory-side responder for the core's L1d `ram_*` port. It accepts word-addressed read and write requests, serves them from an internal byte-writable SRAM after a fixed number of wait states, and answers the core's dcache flush handshake. It sits between the core and on-chip data memory, as the stand-in data memory for simulation and FPGA bring-up.

## Interface
- `DEPTH_LOG2`, default 12: SRAM holds 2^DEPTH_LOG2 32-bit words.
- `BASE_ADDR`, default 32'h0010_0000: byte base of the window. Must be word-aligned and aligned to 4·2^DEPTH_LOG2.
- `WAIT_STATES`, default 1: extra busy cycles per access. Legal range 0..15.
- `clk_i`, in, 1: clock, all logic on the rising edge.
- `rst_i`, in, 1: reset, asynchronous, active-low.
- `ram_addr`, in, 30: word address, equal to byte address[31:2].
- `ram_rd_ready`, in, 1: read request.
- `ram_rd_valid`, out, 1: read data valid, one-cycle pulse.
- `ram_rdata`, out, 32: read data.
- `ram_wr_valid`, in, 1: write request.
- `ram_wr_byte`, in, 4: byte enables, bit i selects wdata[8i+7:8i].
- `ram_wdata`, in, 32: write data.
- `ram_busy`, out, 1: responder cannot accept a request this cycle.
- `flush_dcache_i`, in, 1: flush request, level.
- `flush_dcache_done_o`, out, 1: flush acknowledge, level.
- `err_o`, out, 1: sticky error flag.

## Operation
- Accept rule: a request is accepted on a rising edge where `ram_busy`=0 and (`ram_rd_ready` | `ram_wr_valid`).
  - On accept, addr, wdata, byte enables and kind are latched. The core may change its inputs from the next cycle.
- FSM states:
  - IDLE
  - WAIT: counter counts WAIT_STATES cycles.
  - RESP: single cycle.
  - FLUSH: single cycle.
  - FLUSH_ACK.
- `ram_busy` = 1 in WAIT, FLUSH and FLUSH_ACK. It is 0 in IDLE and RESP.
- Transitions:
  - IDLE or RESP with an accepted request: go to WAIT if WAIT_STATES>0, else RESP.
  - WAIT with counter expired: go to RESP.
  - IDLE or RESP, no request accepted, `flush_dcache_i`=1: go to FLUSH.
  - RESP with nothing pending: go to IDLE.
  - FLUSH: go to FLUSH_ACK.
  - FLUSH_ACK with `flush_dcache_i`=0: go to IDLE.
- Read: `ram_rd_valid`=1 in RESP with `ram_rdata` set to the SRAM word. `ram_rdata` holds its value until the next read response.
- Write: the SRAM byte lanes are updated at the RESP edge. Lanes with enable 0 are untouched. `ram_wr_byte`=0 is a legal no-op.
- Simultaneous rd and wr request: the write is served, the read is dropped, and `err_o` is set.
- Out-of-window address (addr[29:DEPTH_LOG2] ≠ BASE_ADDR[31:DEPTH_LOG2+2]):
  - Write: discarded.
  - Read: returns 0 with a normal `ram_rd_valid`.
  - Both set `err_o`.
- Request and flush in the same accept cycle: the request wins and the flush is taken after RESP.
- `flush_dcache_done_o`=1 only in FLUSH_ACK. The SRAM holds no dirty state, so a flush only drains.
- `err_o` is cleared only by reset.

## Timing
- Reset values:
  - `ram_rd_valid`=0, `ram_rdata`=0, `ram_busy`=0.
  - `flush_dcache_done_o`=0, `err_o`=0.
  - State IDLE.
- Reset mid-operation drops the in-flight access with no response. A write still in WAIT does not reach the SRAM. SRAM contents are not reset.
- Read latency: accept at edge T gives `ram_rd_valid` high in cycle T+WAIT_STATES+1.
- Throughput: one access per WAIT_STATES+1 cycles. Back-to-back accept is allowed in RESP.
- WAIT_STATES=0: `ram_busy` never asserts for data accesses, and one access per cycle is sustained.
- Write then read of the same word in the next accept slot returns the new data.
- Flush, from `flush_dcache_i` rising while IDLE: `ram_busy` rises after 1 cycle and done after 2 cycles.

## Structure
- Package `dmem_pkg`:
  - FSM state enum.
  - Wait counter width constant (4).
  - Window-match helper constant derived from BASE_ADDR.
- Sub-module `dmem_sram`: single-port, 2^DEPTH_LOG2×32, per-byte write enable, synchronous read with 1-cycle latency. The read is issued one cycle before RESP.

## Test plan
- Reset, then write 0xDEADBEEF with bytes 4'b1111 to word 0x0004_0000, then read it. Required: `ram_rd_valid` in cycle T+2 (WAIT_STATES=1) with `ram_rdata`=0xDEADBEEF.
- Write 0x11223344 to a word, then write 0xAABBCCDD with bytes 4'b0101, then read. Required: 0x11BB33DD.
- WAIT_STATES=0, reads to 8 consecutive words issued every cycle. Required: 8 consecutive `ram_rd_valid` pulses, `ram_busy` never high.
- Read of word 0x0000_0000 (outside the window). Required: `ram_rdata`=0, `err_o`=1 and held until reset.
- `flush_dcache_i` raised while a read is accepted in the same cycle. Required: the read response comes first, then `ram_busy` 1 then done 1, and done falls one cycle after `flush_dcache_i` falls.
- `rst_i` pulled low in WAIT of a write. Required: all outputs 0 asynchronously, and a later read shows the old data.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem_responder data-memory stand-in.
package dmem_pkg;

    localparam int unsigned WCNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT      = 3'd1,
        ST_RESP      = 3'd2,
        ST_FLUSH     = 3'd3,
        ST_FLUSH_ACK = 3'd4
    } state_e;

    // Word-address tag that every in-window address carries above the SRAM index bits.
    function automatic logic [29:0] win_tag(input logic [31:0] base, input int unsigned dlog2);
        return base[31:2] >> dlog2;
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port 2^AW x 32 SRAM with per-byte write enables and a registered read port.
module dmem_sram #(
    parameter int unsigned AW = 12
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          re_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [0:(1<<AW)-1];
    logic [31:0] rdata_q;

    // Byte-lane writes; the array itself is deliberately never reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Read register only loads on a read, so it holds the last read word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= 32'd0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end else begin
            rdata_q <= rdata_q;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// L1d ram_* port responder: wait-stated SRAM accesses, window/collision error flag,
// and the dcache flush drain handshake.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [29:0] ram_addr,
    input  logic        ram_rd_ready,
    output logic        ram_rd_valid,
    output logic [31:0] ram_rdata,
    input  logic        ram_wr_valid,
    input  logic [3:0]  ram_wr_byte,
    input  logic [31:0] ram_wdata,
    output logic        ram_busy,
    input  logic        flush_dcache_i,
    output logic        flush_dcache_done_o,
    output logic        err_o
);

    localparam logic [29:0]       WIN_TAG   = win_tag(BASE_ADDR, DEPTH_LOG2);
    localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(WAIT_STATES - 1);

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] cnt_q, cnt_d;
    logic [29:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              rd_q, wr_q;
    logic              busy_q, done_q, rd_valid_q, err_q, rd_zero_q;

    logic              can_acc_s, accept_s, acc_hit_s, from_wait_s, issue_s;
    logic [29:0]       cur_addr_s;
    logic [31:0]       cur_wdata_s, sram_rdata_s;
    logic [3:0]        cur_be_s;
    logic              cur_rd_s, cur_wr_s, in_win_s, sram_re_s, sram_we_s;

    assign can_acc_s = (state_q == ST_IDLE) || (state_q == ST_RESP);
    assign accept_s  = can_acc_s && (ram_rd_ready || ram_wr_valid);
    assign acc_hit_s = ((ram_addr >> DEPTH_LOG2) == WIN_TAG);

    // The access entering RESP comes from the latch after WAIT, or straight from the
    // port when there are no wait states; the SRAM is driven one edge before RESP.
    assign from_wait_s = (state_q == ST_WAIT);
    assign cur_addr_s  = from_wait_s ? addr_q  : ram_addr;
    assign cur_wdata_s = from_wait_s ? wdata_q : ram_wdata;
    assign cur_be_s    = from_wait_s ? be_q    : ram_wr_byte;
    assign cur_wr_s    = from_wait_s ? wr_q    : ram_wr_valid;
    assign cur_rd_s    = from_wait_s ? rd_q    : (ram_rd_ready & ~ram_wr_valid);
    assign in_win_s    = ((cur_addr_s >> DEPTH_LOG2) == WIN_TAG);
    assign issue_s     = (state_d == ST_RESP);
    assign sram_we_s   = issue_s && cur_wr_s && in_win_s;
    assign sram_re_s   = issue_s && cur_rd_s && in_win_s;

    // Next-state and wait-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept_s) begin
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WCNT_LOAD;
                    end else begin
                        state_d = ST_RESP;
                    end
                end else if (flush_dcache_i) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == {WCNT_W{1'b0}}) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - {{(WCNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_FLUSH: begin
                state_d = ST_FLUSH_ACK;
            end
            ST_FLUSH_ACK: begin
                if (!flush_dcache_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FLUSH_ACK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, request latch and registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {WCNT_W{1'b0}};
            addr_q     <= 30'd0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            rd_zero_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= (state_d == ST_WAIT) || (state_d == ST_FLUSH) || (state_d == ST_FLUSH_ACK);
            done_q     <= (state_d == ST_FLUSH_ACK);
            rd_valid_q <= issue_s && cur_rd_s;
            err_q      <= err_q | (accept_s && ((ram_rd_ready && ram_wr_valid) || !acc_hit_s));
            if (accept_s) begin
                addr_q  <= ram_addr;
                wdata_q <= ram_wdata;
                be_q    <= ram_wr_byte;
                wr_q    <= ram_wr_valid;
                rd_q    <= ram_rd_ready & ~ram_wr_valid;
            end
            // Out-of-window reads answer zero without touching the SRAM.
            if (issue_s && cur_rd_s) begin
                rd_zero_q <= !in_win_s;
            end
        end
    end

    dmem_sram #(
        .AW(DEPTH_LOG2)
    ) u_sram (
        .clk_i   (clk_i),
        .rst_ni  (rst_i),
        .re_i    (sram_re_s),
        .we_i    (sram_we_s),
        .be_i    (cur_be_s),
        .addr_i  (cur_addr_s[DEPTH_LOG2-1:0]),
        .wdata_i (cur_wdata_s),
        .rdata_o (sram_rdata_s)
    );

    assign ram_rdata           = rd_zero_q ? 32'd0 : sram_rdata_s;
    assign ram_rd_valid        = rd_valid_q;
    assign ram_busy            = busy_q;
    assign flush_dcache_done_o = done_q;
    assign err_o               = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: dut0 uses one wait state, dut1 has none and shares the same inputs.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [29:0] addr = 30'd0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [3:0]  be = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic        flush = 1'b0;

    logic        rd_valid0, busy0, done0, err0;
    logic [31:0] rdata0;
    logic        rd_valid1, busy1, done1, err1;
    logic [31:0] rdata1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_LOG2(12), .BASE_ADDR(32'h0010_0000), .WAIT_STATES(1)) dut0 (
        .clk_i(clk), .rst_i(rst_n), .ram_addr(addr), .ram_rd_ready(rd),
        .ram_rd_valid(rd_valid0), .ram_rdata(rdata0), .ram_wr_valid(wr),
        .ram_wr_byte(be), .ram_wdata(wdata), .ram_busy(busy0),
        .flush_dcache_i(flush), .flush_dcache_done_o(done0), .err_o(err0)
    );

    dmem_responder #(.DEPTH_LOG2(12), .BASE_ADDR(32'h0010_0000), .WAIT_STATES(0)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .ram_addr(addr), .ram_rd_ready(rd),
        .ram_rd_valid(rd_valid1), .ram_rdata(rdata1), .ram_wr_valid(wr),
        .ram_wr_byte(be), .ram_wdata(wdata), .ram_busy(busy1),
        .flush_dcache_i(flush), .flush_dcache_done_o(done1), .err_o(err1)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic wait_ready0();
        for (int n = 0; n < 20 && busy0; n++) @(negedge clk);
        if (busy0) chk("ready_timeout", 32'(busy0), 32'd0);
    endtask

    task automatic do_write(input logic [29:0] a, input logic [31:0] d, input logic [3:0] b);
        wait_ready0();
        addr = a; wdata = d; be = b; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0; be = 4'd0;
    endtask

    // One wait state: not valid in the cycle after accept, valid in the one after that.
    task automatic do_read(input string tag, input logic [29:0] a, input logic [31:0] exp);
        wait_ready0();
        addr = a; rd = 1'b1;
        @(negedge clk);
        chk({tag, "_early"}, 32'(rd_valid0), 32'd0);
        rd = 1'b0;
        @(negedge clk);
        chk({tag, "_valid"}, 32'(rd_valid0), 32'd1);
        chk({tag, "_data"}, rdata0, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_rd_valid", 32'(rd_valid0), 32'd0);
        chk("rst_rdata", rdata0, 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_err", 32'(err0), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full write then read back with exact latency, plus rdata hold.
        do_write(30'h0004_0000, 32'hDEAD_BEEF, 4'b1111);
        chk("wr_busy_wait", 32'(busy0), 32'd1);
        do_read("rd_beef", 30'h0004_0000, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("hold_valid", 32'(rd_valid0), 32'd0);
        chk("hold_data", rdata0, 32'hDEAD_BEEF);

        // Byte-lane merge and zero-enable no-op.
        do_write(30'h0004_0010, 32'h1122_3344, 4'b1111);
        do_write(30'h0004_0010, 32'hAABB_CCDD, 4'b0101);
        do_read("rd_merge", 30'h0004_0010, 32'h11BB_33DD);
        do_write(30'h0004_0010, 32'hFFFF_FFFF, 4'b0000);
        do_read("rd_noop", 30'h0004_0010, 32'h11BB_33DD);

        // Zero-wait instance: one access per cycle, never busy.
        for (int i = 0; i < 8; i++) begin
            addr = 30'h0004_0100 + 30'(i); wdata = 32'hC0DE_0000 + 32'(i); be = 4'b1111; wr = 1'b1;
            @(negedge clk);
            chk("burst_wr_busy", 32'(busy1), 32'd0);
        end
        wr = 1'b0; be = 4'd0;
        for (int i = 0; i < 8; i++) begin
            addr = 30'h0004_0100 + 30'(i); rd = 1'b1;
            @(negedge clk);
            chk("burst_valid", 32'(rd_valid1), 32'd1);
            chk("burst_data", rdata1, 32'hC0DE_0000 + 32'(i));
            chk("burst_busy", 32'(busy1), 32'd0);
        end
        rd = 1'b0;
        @(negedge clk);
        chk("burst_end", 32'(rd_valid1), 32'd0);

        // Out-of-window accesses: zero read data, no aliasing write, sticky error.
        wait_ready0();
        chk("err_pre", 32'(err0), 32'd0);
        do_read("rd_oow", 30'h0000_0000, 32'd0);
        chk("err_oow", 32'(err0), 32'd1);
        do_write(30'h0000_0010, 32'h0000_0000, 4'b1111);
        do_read("rd_alias", 30'h0004_0010, 32'h11BB_33DD);
        chk("err_held", 32'(err0), 32'd1);

        // Read and flush in the same accept cycle: response first, then drain.
        wait_ready0();
        addr = 30'h0004_0000; rd = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("fl_wait_busy", 32'(busy0), 32'd1);
        chk("fl_wait_done", 32'(done0), 32'd0);
        rd = 1'b0;
        @(negedge clk);
        chk("fl_resp_valid", 32'(rd_valid0), 32'd1);
        chk("fl_resp_data", rdata0, 32'hDEAD_BEEF);
        chk("fl_resp_busy", 32'(busy0), 32'd0);
        @(negedge clk);
        chk("fl_busy", 32'(busy0), 32'd1);
        chk("fl_busy_done", 32'(done0), 32'd0);
        @(negedge clk);
        chk("fl_done", 32'(done0), 32'd1);
        @(negedge clk);
        chk("fl_done_hold", 32'(done0), 32'd1);
        flush = 1'b0;
        @(negedge clk);
        chk("fl_done_fall", 32'(done0), 32'd0);
        chk("fl_busy_fall", 32'(busy0), 32'd0);
        chk("fl_err_held", 32'(err0), 32'd1);

        // Asynchronous reset during the wait state of a write.
        wait_ready0();
        addr = 30'h0004_0000; wdata = 32'h1234_5678; be = 4'b1111; wr = 1'b1;
        @(negedge clk);
        chk("ar_pre_busy", 32'(busy0), 32'd1);
        wr = 1'b0; be = 4'd0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy", 32'(busy0), 32'd0);
        chk("ar_valid", 32'(rd_valid0), 32'd0);
        chk("ar_rdata", rdata0, 32'd0);
        chk("ar_done", 32'(done0), 32'd0);
        chk("ar_err", 32'(err0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_read("rd_after_rst", 30'h0004_0000, 32'hDEAD_BEEF);
        chk("err_after_rst", 32'(err0), 32'd0);

        // Simultaneous read and write: write served, read dropped, error set.
        wait_ready0();
        addr = 30'h0004_0020; wdata = 32'h55AA_55AA; be = 4'b1111; rd = 1'b1; wr = 1'b1;
        @(negedge clk);
        chk("rw_no_valid0", 32'(rd_valid0), 32'd0);
        rd = 1'b0; wr = 1'b0; be = 4'd0;
        @(negedge clk);
        chk("rw_no_valid1", 32'(rd_valid0), 32'd0);
        chk("rw_err", 32'(err0), 32'd1);
        do_read("rd_rw", 30'h0004_0020, 32'h55AA_55AA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
